// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg
// Shared bus widths and the slave state encoding for the multiplexed-address
// memory bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  localparam int ADDR_BYTE_W = 8;
  localparam int DATA_W      = 8;
  localparam int WAIT_W      = 4;

  // SA idle, SB lower address, SC read data, SD write data
  typedef enum logic [1:0] {
    SA = 2'd0,
    SB = 2'd1,
    SC = 2'd2,
    SD = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_byte_array.sv
// ============================================================================
// mem_byte_array
// 256 x 8 storage: one synchronous write port, one combinational read port.
// No reset: contents survive resetN and are undefined until first written.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_byte_array
  import mem_bus_pkg::*;
(
  input  logic                   clock,
  input  logic                   we,
  input  logic [ADDR_BYTE_W-1:0] waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [ADDR_BYTE_W-1:0] raddr,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_BYTE_W)-1];

  // Byte write on the clock edge when enabled
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_int_thread.sv
// ============================================================================
// mem_int_thread
// Bus slave on a multiplexed-address, tri-state data bus. Answers to one
// upper-address page; reads return after RD_WAIT wait cycles, writes complete
// when the master strobes dataValid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_int_thread
  import mem_bus_pkg::*;
#(
  parameter logic [ADDR_BYTE_W-1:0] PAGE    = 8'h00,
  parameter int                     RD_WAIT = 0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   read,
  input  logic [ADDR_BYTE_W-1:0] address,
  inout  logic                   dataValid,
  inout  logic [DATA_W-1:0]      data
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t                 state_q,   state_d;
  logic [ADDR_BYTE_W-1:0] addr_hi_q, addr_hi_d;
  logic [ADDR_BYTE_W-1:0] addr_lo_q, addr_lo_d;
  logic                   read_q,    read_d;
  logic [WAIT_W-1:0]      cnt_q,     cnt_d;
  logic                   dv_oe_q,   dv_oe_d;
  logic                   dv_q,      dv_d;
  logic                   data_oe_q, data_oe_d;
  logic [DATA_W-1:0]      data_q,    data_d;

  logic                   selected;
  logic                   mem_we;
  logic [ADDR_BYTE_W-1:0] mem_raddr;
  logic [DATA_W-1:0]      mem_rdata;

  assign selected = (addr_hi_q == PAGE);

  // Write only from SD of a selected write, on the edge the master strobes
  assign mem_we = (state_q == SD) && !read_q && selected && (dataValid == 1'b1);

  // In SB the lower address is still on the bus, so read through it directly
  // to have the byte ready for a zero-wait first SC cycle.
  assign mem_raddr = (state_q == SB) ? address : addr_lo_q;

  mem_byte_array u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (addr_lo_q),
    .wdata (data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Next-state, address latch, wait counter and next bus-drive computation
  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    addr_lo_d = addr_lo_q;
    read_d    = read_q;
    cnt_d     = cnt_q;
    dv_oe_d   = 1'b0;
    dv_d      = 1'b0;
    data_oe_d = 1'b0;
    data_d    = data_q;
    case (state_q)
      SA: begin
        if (start) begin
          addr_hi_d = address;
          state_d   = SB;
        end
      end
      SB: begin
        addr_lo_d = address;
        read_d    = read;
        if (read) begin
          state_d   = SC;
          cnt_d     = WAIT_INIT;
          dv_oe_d   = selected;
          dv_d      = (WAIT_INIT == '0);
          data_oe_d = selected && (WAIT_INIT == '0);
          data_d    = mem_rdata;
        end else begin
          state_d = SD;
        end
      end
      SC: begin
        if (cnt_q == '0) begin
          state_d = SA;
        end else begin
          // Drive low while waiting; the last decrement lands on the data cycle
          cnt_d     = cnt_q - WAIT_ONE;
          dv_oe_d   = selected;
          dv_d      = (cnt_q == WAIT_ONE);
          data_oe_d = selected && (cnt_q == WAIT_ONE);
          data_d    = mem_rdata;
        end
      end
      SD: begin
        if (dataValid == 1'b1) begin
          state_d = SA;
        end
      end
      default: state_d = SA;
    endcase
  end

  // State and registered bus drive; reset aborts any transaction in flight
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= SA;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      read_q    <= 1'b0;
      cnt_q     <= '0;
      dv_oe_q   <= 1'b0;
      dv_q      <= 1'b0;
      data_oe_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      addr_lo_q <= addr_lo_d;
      read_q    <= read_d;
      cnt_q     <= cnt_d;
      dv_oe_q   <= dv_oe_d;
      dv_q      <= dv_d;
      data_oe_q <= data_oe_d;
      data_q    <= data_d;
    end
  end

  assign dataValid = dv_oe_q   ? dv_q   : 1'bz;
  assign data      = data_oe_q ? data_q : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_mem_int_thread.sv
// ============================================================================
// tb_mem_int_thread
// Two slaves share one bus: page 00 with zero read wait, page 02 with three
// wait cycles. Undriven data floats to FF and dataValid to 0 through the net
// types, so any slave drive outside its own read data cycle shows on the bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_int_thread;

  logic       clock;
  logic       resetN;
  logic       start;
  logic       read;
  logic [7:0] address;
  tri0        dataValid;
  tri1  [7:0] data;

  logic       m_dv_en;
  logic       m_dv;
  logic       m_data_en;
  logic [7:0] m_data;

  assign dataValid = m_dv_en   ? m_dv   : 1'bz;
  assign data      = m_data_en ? m_data : 8'hzz;

  mem_int_thread #(.PAGE(8'h00), .RD_WAIT(0)) dut0 (
    .clock(clock), .resetN(resetN), .start(start), .read(read),
    .address(address), .dataValid(dataValid), .data(data)
  );

  mem_int_thread #(.PAGE(8'h02), .RD_WAIT(3)) dut1 (
    .clock(clock), .resetN(resetN), .start(start), .read(read),
    .address(address), .dataValid(dataValid), .data(data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dat;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: a slave strobe pops the scoreboard; otherwise the bus must float
  always @(negedge clock) begin
    exp_t e;
    if (!m_dv_en && dataValid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got data=%h at cycle %0d, required no strobe", data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (data !== e.dat || cyc != e.at) begin
          errors++;
          $display("FAIL read_data: got data=%h at cycle %0d, required data=%h at cycle %0d",
                   data, cyc, e.dat, e.at);
        end
      end
    end else if (!m_data_en) begin
      checks++;
      if (data !== 8'hFF) begin
        errors++;
        $display("FAIL bus_idle: got data=%h dataValid=%b at cycle %0d, required data released",
                 data, dataValid, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Write transaction; gap = idle cycles in SD before the master strobes
  task automatic do_write(input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] val, input int gap);
    start = 1'b1; address = hi;
    tick();
    start = 1'b0; address = lo; read = 1'b0;
    tick();
    repeat (gap) tick();
    m_dv_en = 1'b1; m_dv = 1'b1; m_data_en = 1'b1; m_data = val;
    tick();
    m_dv_en = 1'b0; m_dv = 1'b0; m_data_en = 1'b0;
  endtask

  // Read transaction; exp_valid says whether some slave must answer with
  // want after wt wait cycles. poke pulses start in the first SC cycle.
  task automatic do_read(input logic [7:0] hi, input logic [7:0] lo,
                         input bit exp_valid, input logic [7:0] want,
                         input int wt, input bit poke);
    exp_t e;
    start = 1'b1; address = hi;
    tick();
    start = 1'b0; address = lo; read = 1'b1;
    tick();
    if (exp_valid) begin
      e.dat = want;
      e.at  = cyc + wt;
      exp_q.push_back(e);
    end
    if (poke) begin
      start = 1'b1; address = hi;
      tick();
      start = 1'b0; address = lo;
      repeat (3) tick();
    end else begin
      repeat (4) tick();
    end
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; read = 1'b0; address = 8'h00;
    m_dv_en = 1'b0; m_dv = 1'b0; m_data_en = 1'b0; m_data = 8'h00;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    tick();

    // Selected write with a two-cycle master gap, then zero-wait read back
    do_write(8'h00, 8'h3C, 8'hA5, 2);
    do_read (8'h00, 8'h3C, 1'b1, 8'hA5, 0, 1'b0);

    // Same byte in the three-wait slave
    do_write(8'h02, 8'h3C, 8'hA5, 1);
    do_read (8'h02, 8'h3C, 1'b1, 8'hA5, 3, 1'b0);

    // Unselected page: write must not land anywhere, read must stay silent
    do_write(8'h01, 8'h3C, 8'h77, 0);
    do_read (8'h00, 8'h3C, 1'b1, 8'hA5, 0, 1'b0);
    do_read (8'h02, 8'h3C, 1'b1, 8'hA5, 3, 1'b0);
    do_read (8'h01, 8'h3C, 1'b0, 8'h00, 0, 1'b0);

    // Reset while parked in SD; a strobe during reset must not write
    start = 1'b1; address = 8'h00;
    tick();
    start = 1'b0; address = 8'h3C; read = 1'b0;
    tick();
    tick();
    resetN = 1'b0;
    @(negedge clock);
    #1;
    m_dv_en = 1'b1; m_dv = 1'b1; m_data_en = 1'b1; m_data = 8'h55;
    @(posedge clock);
    #1;
    m_dv_en = 1'b0; m_dv = 1'b0; m_data_en = 1'b0;
    resetN = 1'b1;
    tick();
    do_read (8'h00, 8'h3C, 1'b1, 8'hA5, 0, 1'b0);
    do_write(8'h00, 8'h3C, 8'h5A, 0);
    do_read (8'h00, 8'h3C, 1'b1, 8'h5A, 0, 1'b0);

    // Back-to-back write/read with a stray start during SC
    do_write(8'h00, 8'h10, 8'hC3, 0);
    do_read (8'h00, 8'h10, 1'b1, 8'hC3, 0, 1'b1);
    do_write(8'h02, 8'h10, 8'h3C, 0);
    do_read (8'h02, 8'h10, 1'b1, 8'h3C, 3, 1'b1);

    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_reads: got %0d unanswered reads, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
